// File: rtl/krnl_partial_knn_local_sp_uram_sdp_if.sv
// ---------------------------------------------------------------------------
// krnl_partial_knn_local_sp_uram_sdp_if
//   Bus bundle for the simple-dual-port local SP scratchpad.
//   master : drives write port (wr_en/wr_addr/wr_be/wr_data) and read request
//            (rd_en/rd_addr); observes rd_data/rd_valid/rd_oor.
//   slave  : the scratchpad side of the same signals.
// ---------------------------------------------------------------------------
interface krnl_partial_knn_local_sp_uram_sdp_if #(
    parameter int DataWidth    = 256,
    parameter int ByteWidth    = 8,
    parameter int AddressWidth = 11
);
    localparam int NumBytes = DataWidth / ByteWidth;

    logic                    wr_en;
    logic [AddressWidth-1:0] wr_addr;
    logic [NumBytes-1:0]     wr_be;
    logic [DataWidth-1:0]    wr_data;
    logic                    rd_en;
    logic [AddressWidth-1:0] rd_addr;
    logic [DataWidth-1:0]    rd_data;
    logic                    rd_valid;
    logic                    rd_oor;

    modport master (
        output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_oor
    );

    modport slave (
        input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, rd_oor
    );
endinterface

// File: rtl/krnl_partial_knn_local_sp_uram_sdp.sv
// ---------------------------------------------------------------------------
// krnl_partial_knn_local_sp_uram_sdp
//   Simple-dual-port local search-point scratchpad (URAM-style array).
//   One byte-masked write port and one read port per cycle on one clock.
//   Reads snapshot the array at the issue edge with write-first bypass for a
//   same-edge write to the same word, then travel through ReadLatency stages
//   before appearing on registered rd_data/rd_valid/rd_oor.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset (read pipeline and outputs only;
//            the array keeps its contents)
//   bus    : slave side of krnl_partial_knn_local_sp_uram_sdp_if
// ---------------------------------------------------------------------------
module krnl_partial_knn_local_sp_uram_sdp #(
    parameter int DataWidth    = 256,
    parameter int ByteWidth    = 8,
    parameter int AddressRange = 2048,
    parameter int AddressWidth = 11,
    parameter int ReadLatency  = 2
) (
    input  logic clk,
    input  logic reset,
    krnl_partial_knn_local_sp_uram_sdp_if.slave bus
);
    localparam int NumBytes = DataWidth / ByteWidth;
    // One extra bit so AddressRange == 2**AddressWidth is representable.
    localparam logic [AddressWidth:0] AddrLimit = (AddressWidth + 1)'(AddressRange);

    if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
        $error("ReadLatency must be in 1..4");
    end
    if ((DataWidth % ByteWidth) != 0) begin : g_bad_width
        $error("DataWidth must be a multiple of ByteWidth");
    end

    logic [DataWidth-1:0]    mem_r [AddressRange];

    logic                    wr_in_range_s;
    logic                    wr_hit_s;
    logic                    rd_in_range_s;
    logic                    collide_s;
    logic [AddressWidth-1:0] rd_index_s;
    logic [DataWidth-1:0]    mem_word_s;
    logic [DataWidth-1:0]    rd_word_s;

    logic [DataWidth-1:0]    pipe_data_r [ReadLatency];
    logic [ReadLatency-1:0]  pipe_vld_r;
    logic [ReadLatency-1:0]  pipe_oor_r;

    logic [DataWidth-1:0]    rd_data_r;
    logic                    rd_valid_r;
    logic                    rd_oor_r;

    // Address qualification: writes are dropped while reset is held.
    always_comb begin
        wr_in_range_s = ({1'b0, bus.wr_addr} < AddrLimit);
        rd_in_range_s = ({1'b0, bus.rd_addr} < AddrLimit);
        wr_hit_s      = bus.wr_en & wr_in_range_s & ~reset;
        collide_s     = wr_hit_s & bus.rd_en & rd_in_range_s & (bus.rd_addr == bus.wr_addr);
        // Out-of-range reads never touch the array; park the index at 0.
        if (rd_in_range_s) begin
            rd_index_s = bus.rd_addr;
        end else begin
            rd_index_s = '0;
        end
    end

    assign mem_word_s = mem_r[rd_index_s];

    // Read snapshot: old word, with same-edge written lanes forwarded.
    always_comb begin
        rd_word_s = '0;
        if (rd_in_range_s) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (collide_s && bus.wr_be[i]) begin
                    rd_word_s[i*ByteWidth +: ByteWidth] = bus.wr_data[i*ByteWidth +: ByteWidth];
                end else begin
                    rd_word_s[i*ByteWidth +: ByteWidth] = mem_word_s[i*ByteWidth +: ByteWidth];
                end
            end
        end else begin
            rd_word_s = '0;
        end
    end

    // Byte-masked array write; no reset so the array can map onto URAM.
    always_ff @(posedge clk) begin
        if (wr_hit_s) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (bus.wr_be[i]) begin
                    mem_r[bus.wr_addr][i*ByteWidth +: ByteWidth] <= bus.wr_data[i*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures the snapshot, later stages shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_r <= '0;
            pipe_oor_r <= '0;
            for (int k = 0; k < ReadLatency; k++) begin
                pipe_data_r[k] <= '0;
            end
        end else begin
            pipe_vld_r[0]  <= bus.rd_en;
            pipe_oor_r[0]  <= bus.rd_en & ~rd_in_range_s;
            pipe_data_r[0] <= rd_word_s;
            for (int k = 1; k < ReadLatency; k++) begin
                pipe_vld_r[k]  <= pipe_vld_r[k-1];
                pipe_oor_r[k]  <= pipe_oor_r[k-1];
                pipe_data_r[k] <= pipe_data_r[k-1];
            end
        end
    end

    // Output register: rd_data holds its last value between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_oor_r   <= 1'b0;
        end else begin
            rd_valid_r <= pipe_vld_r[ReadLatency-1];
            rd_oor_r   <= pipe_vld_r[ReadLatency-1] & pipe_oor_r[ReadLatency-1];
            if (pipe_vld_r[ReadLatency-1]) begin
                rd_data_r <= pipe_data_r[ReadLatency-1];
            end
        end
    end

    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_oor   = rd_oor_r;
endmodule
